// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters and branch/mispredict statistics.
// Predicts direction and target for the fetch PC and is trained by resolved branches from EX.
module branch_predictor #(
  parameter int ENTRIES = 16,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_update,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        ex_mispredict,
  input  logic        bp_flush,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);
  localparam int TAG_W = 30 - IDX_W;
  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [31:0]      r_stat_branches;
  logic [31:0]      r_stat_mispredicts;
  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic [1:0]       w_ex_ctr;
  logic [1:0]       w_ctr_next;
  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_if_tag = if_pc[31:IDX_W+2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[31:IDX_W+2];
  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign pred_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign pred_taken  = pred_hit && r_ctr[w_if_idx][1];
  assign pred_target = pred_taken ? r_target[w_if_idx] : if_pc + 32'd4;
  assign ex_mispredict = ex_update &&
    ((ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target)));
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ex_ctr = r_ctr[w_ex_idx];
  assign w_ctr_next = ex_taken ? ((w_ex_ctr == 2'b11) ? 2'b11 : w_ex_ctr + 2'd1)
                               : ((w_ex_ctr == 2'b00) ? 2'b00 : w_ex_ctr - 2'd1);
  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_ctr[i]    <= 2'b01;
        r_target[i] <= '0;
      end
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (ex_update) r_stat_branches <= r_stat_branches + 32'd1;
      if (ex_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
      // Flush drops only valid bits and suppresses any allocation this cycle.
      if (bp_flush) begin
        for (int i = 0; i < ENTRIES; i++) r_valid[i] <= 1'b0;
      end else if (ex_update) begin
        if (w_ex_hit) begin
          r_ctr[w_ex_idx] <= w_ctr_next;
          if (ex_taken) r_target[w_ex_idx] <= ex_target;
        end else if (ex_taken) begin
          r_valid[w_ex_idx]  <= 1'b1;
          r_tag[w_ex_idx]    <= w_ex_tag;
          r_ctr[w_ex_idx]    <= 2'b10;
          r_target[w_ex_idx] <= ex_target;
        end
      end
    end
  end
endmodule
